eink_fb_writer: RTL and testbench

EINK_FB_WRITER -- requirements
Module: eink_fb_writer

---
 rtl/eink_fb_writer.sv | 234 +++++++++++++++++++++++
 tb/tb_eink_fb_writer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eink_fb_writer.sv
// eink_fb_writer: packs host bytes (two 4-bit pixels each) into 16-bit words
// and writes them into the e-ink frame-buffer SRAM. The SRAM is shared with
// the display controller. When disp_ready is high this block owns the SRAM;
// when it is low the controller's read address passes straight through.
//
// Optional feature: define FB_WINDOW_EN to restrict the load to the
// rectangle win_x1..win_x2 x win_y1..win_y2. The bounds are sampled at
// frame_start. Without the macro the whole SOURCE_SIZE x GATE_SIZE frame is
// loaded and the window ports are ignored.
module eink_fb_writer #(
  parameter int SOURCE_SIZE = 200,
  parameter int GATE_SIZE   = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        host_valid,
  input  logic [7:0]  host_data,
  output logic        host_ready,
  input  logic [7:0]  win_x1,
  input  logic [7:0]  win_x2,
  input  logic [9:0]  win_y1,
  input  logic [9:0]  win_y2,
  input  logic        disp_ready,
  input  logic [16:0] disp_address,
  output logic [15:0] disp_data,
  output logic [16:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_we,
  input  logic [15:0] sram_rdata,
  output logic        busy,
  output logic        done
);

  localparam logic [16:0] LINE_STEP = 17'(SOURCE_SIZE);
  localparam logic [7:0]  X_LAST    = 8'(SOURCE_SIZE - 1);
  localparam logic [9:0]  Y_LAST    = 10'(GATE_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    STALL = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Writer position and packed word
  logic [7:0]  x;
  logic [9:0]  y;
  logic [16:0] addr;
  logic [16:0] line_base;
  logic [15:0] word;

  // Frame bounds and start values
  logic [7:0]  x_start;
  logic [7:0]  x_end;
  logic [9:0]  y_end;
  logic        inverted;
  logic [7:0]  start_x;
  logic [9:0]  start_y;
  logic [16:0] start_base;

  // Control strobes from the FSM to the datapath
  logic start;
  logic load_hi;
  logic load_lo;
  logic advance;
  logic last;

`ifdef FB_WINDOW_EN
  logic [9:0] y_start;

  assign start_x    = win_x1;
  assign start_y    = win_y1;
  assign start_base = 17'(win_y1) * LINE_STEP;
  // An empty rectangle finishes without writing anything
  assign inverted   = (x_start > x_end) || (y_start > y_end);

  // Capture the window at frame_start so it stays stable for the whole load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_start <= 8'd0;
      x_end   <= 8'd0;
      y_start <= 10'd0;
      y_end   <= 10'd0;
    end else if (start) begin
      x_start <= win_x1;
      x_end   <= win_x2;
      y_start <= win_y1;
      y_end   <= win_y2;
    end
  end
`else
  logic win_unused;

  assign start_x    = 8'd0;
  assign start_y    = 10'd0;
  assign start_base = 17'd0;
  assign x_start    = 8'd0;
  assign x_end      = X_LAST;
  assign y_end      = Y_LAST;
  assign inverted   = 1'b0;
  assign win_unused = ^{win_x1, win_x2, win_y1, win_y2};
`endif

  assign last = (x == x_end) && (y == y_end);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, handshake and datapath strobes
  always_comb begin
    state_nxt  = state;
    host_ready = 1'b0;
    sram_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    start      = 1'b0;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          start     = 1'b1;
          state_nxt = HI;
        end else begin
          state_nxt = IDLE;
        end
      end
      HI: begin
        busy = 1'b1;
        if (inverted) begin
          state_nxt = DONE;
        end else begin
          host_ready = 1'b1;
          if (host_valid) begin
            load_hi   = 1'b1;
            state_nxt = LO;
          end else begin
            state_nxt = HI;
          end
        end
      end
      LO: begin
        busy       = 1'b1;
        host_ready = 1'b1;
        if (host_valid) begin
          load_lo   = 1'b1;
          state_nxt = disp_ready ? WRITE : STALL;
        end else begin
          state_nxt = LO;
        end
      end
      WRITE: begin
        busy = 1'b1;
        // Losing the SRAM during the write cycle cancels it; retry from STALL
        if (disp_ready) begin
          sram_we   = 1'b1;
          advance   = 1'b1;
          state_nxt = last ? DONE : HI;
        end else begin
          state_nxt = STALL;
        end
      end
      STALL: begin
        busy = 1'b1;
        if (disp_ready) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = STALL;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Word packing and raster address generation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= 8'd0;
      y         <= 10'd0;
      addr      <= 17'd0;
      line_base <= 17'd0;
      word      <= 16'd0;
    end else if (start) begin
      x         <= start_x;
      y         <= start_y;
      addr      <= start_base + {9'd0, start_x};
      line_base <= start_base;
    end else if (load_hi) begin
      word[15:8] <= host_data;
    end else if (load_lo) begin
      word[7:0] <= host_data;
    end else if (advance) begin
      if (x != x_end) begin
        x    <= x + 8'd1;
        addr <= addr + 17'd1;
      end else if (y != y_end) begin
        x         <= x_start;
        y         <= y + 10'd1;
        addr      <= line_base + LINE_STEP + {9'd0, x_start};
        line_base <= line_base + LINE_STEP;
      end
    end
  end

  // SRAM ownership mux and controller read-data pass-through
  always_comb begin
    if (disp_ready) begin
      sram_addr = addr;
    end else begin
      sram_addr = disp_address;
    end
    sram_wdata = word;
    disp_data  = sram_rdata;
  end

endmodule

// File: tb/tb_eink_fb_writer.sv
// Self-checking bench for eink_fb_writer. A small panel geometry keeps full
// frames short; the window build uses the default geometry so window
// addresses match the real panel.
module tb_eink_fb_writer;

`ifdef FB_WINDOW_EN
  localparam int SS = 200;
  localparam int GS = 600;
`else
  localparam int SS = 8;
  localparam int GS = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_ready;
  logic [7:0]  win_x1, win_x2;
  logic [9:0]  win_y1, win_y2;
  logic        disp_ready;
  logic [16:0] disp_address;
  logic [15:0] disp_data;
  logic [16:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        sram_we;
  logic [15:0] sram_rdata;
  logic        busy;
  logic        done;

  eink_fb_writer #(.SOURCE_SIZE(SS), .GATE_SIZE(GS)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .win_x1(win_x1), .win_x2(win_x2), .win_y1(win_y1), .win_y2(win_y2),
    .disp_ready(disp_ready), .disp_address(disp_address), .disp_data(disp_data),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_rdata(sram_rdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write and done monitor, sampled mid-cycle
  logic [16:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  always @(negedge clk) begin
    if (sram_we) begin
      wa_q.push_back(sram_addr);
      wd_q.push_back(sram_wdata);
      wc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int total  = 0;
  int passed = 0;
  int fs_cyc = 0;

  typedef struct {
    logic        dr;
    logic        hv;
    logic [16:0] da;
    logic [15:0] rd;
    logic [16:0] e_addr;
    logic        e_we;
    logic        e_hr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expire(input string name);
    total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    fs_cyc = cyc;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    host_valid = 1'b1;
    host_data  = b;
    while (!host_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) expire("host_handshake");
    tick();
    host_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) expire("wait_done");
  endtask

  // Drives one frame with the given window ports and checks the write stream
  task automatic run_frame(input int x1, input int x2, input int y1, input int y2,
                           input int mode, input bit poke_fs);
    int ex1, ex2, ey1, ey2, nw, wb, db, k, aerr, derr;
    logic [7:0] hb, lb;
    logic [16:0] ea;
    logic [15:0] ed;
`ifdef FB_WINDOW_EN
    ex1 = x1; ex2 = x2; ey1 = y1; ey2 = y2;
`else
    ex1 = 0; ex2 = SS - 1; ey1 = 0; ey2 = GS - 1;
`endif
    win_x1 = 8'(x1); win_x2 = 8'(x2); win_y1 = 10'(y1); win_y2 = 10'(y2);
    nw = (ex2 - ex1 + 1) * (ey2 - ey1 + 1);
    wb = wa_q.size();
    db = done_cnt;
    chk("busy_before_fs", busy, 0);
    pulse_fs();
    chk("busy_after_fs", busy, 1);
    for (int i = 0; i < nw; i++) begin
      hb = (mode == 0) ? 8'h12 : 8'(i);
      lb = (mode == 0) ? 8'h34 : ~8'(i);
      if (poke_fs && i == 5) frame_start = 1'b1;
      send_byte(hb);
      frame_start = 1'b0;
      send_byte(lb);
    end
    wait_done(db, 50);
    tick();
    chk("frame_nwrites", wa_q.size() - wb, nw);
    chk("frame_done_cnt", done_cnt - db, 1);
    chk("busy_after_done", busy, 0);
    aerr = 0;
    derr = 0;
    k = 0;
    for (int yy = ey1; yy <= ey2; yy++) begin
      for (int xx = ex1; xx <= ex2; xx++) begin
        ea = 17'(yy * SS + xx);
        ed = (mode == 0) ? 16'h1234 : {8'(k), ~8'(k)};
        if (wb + k < wa_q.size()) begin
          if (wa_q[wb + k] !== ea) aerr++;
          if (wd_q[wb + k] !== ed) derr++;
        end
        k++;
      end
    end
    chk("frame_addr_errors", aerr, 0);
    chk("frame_data_errors", derr, 0);
    if (wa_q.size() > wb) begin
      chk("frame_first_addr", wa_q[wb], 32'(ey1 * SS + ex1));
      chk("done_after_last_write", done_cyc, wc_q[wc_q.size() - 1] + 1);
    end else begin
      expire("frame_no_writes");
    end
  endtask

  vec_t vecs[4];

  initial begin
    int wb, db;

    vecs[0] = '{dr:1'b0, hv:1'b1, da:17'h1FFFF, rd:16'h0000, e_addr:17'h1FFFF, e_we:1'b0, e_hr:1'b0};
    vecs[1] = '{dr:1'b0, hv:1'b0, da:17'h12345, rd:16'hA5A5, e_addr:17'h12345, e_we:1'b0, e_hr:1'b0};
    vecs[2] = '{dr:1'b1, hv:1'b1, da:17'h1FFFF, rd:16'h5A5A, e_addr:17'h00000, e_we:1'b0, e_hr:1'b0};
    vecs[3] = '{dr:1'b0, hv:1'b1, da:17'd119999, rd:16'hFFFF, e_addr:17'd119999, e_we:1'b0, e_hr:1'b0};

    rst = 1'b1; frame_start = 1'b0; host_valid = 1'b0; host_data = 8'h00;
    win_x1 = 8'd0; win_x2 = 8'(SS - 1); win_y1 = 10'd0; win_y2 = 10'(GS - 1);
    disp_ready = 1'b1; disp_address = 17'd0; sram_rdata = 16'h0000;
    #1;
    chk("rst_sram_we", sram_we, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_addr", sram_addr, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Idle mux / pass-through table
    for (int i = 0; i < 4; i++) begin
      disp_ready   = vecs[i].dr;
      host_valid   = vecs[i].hv;
      disp_address = vecs[i].da;
      sram_rdata   = vecs[i].rd;
      #1;
      chk("idle_sram_addr", sram_addr, vecs[i].e_addr);
      chk("idle_disp_data", disp_data, vecs[i].rd);
      chk("idle_sram_we", sram_we, vecs[i].e_we);
      chk("idle_host_ready", host_ready, vecs[i].e_hr);
      tick();
    end
    host_valid = 1'b0;
    disp_ready = 1'b1;
    chk("idle_no_writes", wa_q.size(), 0);

`ifdef FB_WINDOW_EN
    run_frame(10, 12, 5, 6, 0, 1'b0);
    run_frame(10, 12, 5, 6, 1, 1'b1);
    // Empty window completes without writes
    win_x1 = 8'd20; win_x2 = 8'd10; win_y1 = 10'd0; win_y2 = 10'd0;
    wb = wa_q.size();
    db = done_cnt;
    pulse_fs();
    wait_done(db, 20);
    tick();
    chk("inv_done_cnt", done_cnt - db, 1);
    chk("inv_done_cycle", done_cyc, fs_cyc + 2);
    chk("inv_no_writes", wa_q.size() - wb, 0);
`else
    run_frame(0, SS - 1, 0, GS - 1, 0, 1'b0);
    run_frame(20, 10, 5, 1, 1, 1'b1);
`endif

    // Arbitration: controller takes the SRAM after the LO byte
    do_reset();
    win_x1 = 8'd0; win_x2 = 8'(SS - 1); win_y1 = 10'd0; win_y2 = 10'(GS - 1);
    wb = wa_q.size();
    pulse_fs();
    send_byte(8'hAB);
    disp_ready = 1'b0;
    disp_address = 17'h1ABCD;
    sram_rdata = 16'hBEEF;
    send_byte(8'hCD);
    for (int j = 0; j < 3; j++) begin
      chk("stall_we", sram_we, 0);
      chk("stall_addr", sram_addr, 17'h1ABCD);
      chk("stall_host_ready", host_ready, 0);
      tick();
    end
    chk("stall_disp_data", disp_data, 16'hBEEF);
    chk("stall_busy", busy, 1);
    disp_ready = 1'b1;
    #1;
    chk("rise_no_we_yet", sram_we, 0);
    tick();
    chk("rise_write_we", sram_we, 1);
    chk("rise_write_addr", sram_addr, 0);
    chk("rise_write_data", sram_wdata, 16'hABCD);
    tick();
    // Grant lost during the write cycle itself
    send_byte(8'h11);
    send_byte(8'h22);
    chk("write_we_after_lo", sram_we, 1);
    chk("write_addr_after_lo", sram_addr, 1);
    disp_ready = 1'b0;
    #1;
    chk("write_suppressed", sram_we, 0);
    tick();
    chk("resume_stall_we", sram_we, 0);
    chk("resume_stall_hr", host_ready, 0);
    disp_ready = 1'b1;
    tick();
    chk("retry_we", sram_we, 1);
    chk("retry_addr", sram_addr, 1);
    chk("retry_data", sram_wdata, 16'h1122);
    tick();
    chk("arb_nwrites", wa_q.size() - wb, 2);
    if (wa_q.size() - wb == 2) begin
      chk("arb_w0_addr", wa_q[wb], 0);
      chk("arb_w0_data", wd_q[wb], 16'hABCD);
      chk("arb_w1_addr", wa_q[wb + 1], 1);
      chk("arb_w1_data", wd_q[wb + 1], 16'h1122);
    end

    // Reset in the middle of a word
    do_reset();
    wb = wa_q.size();
    pulse_fs();
    send_byte(8'h55);
    rst = 1'b1;
    #1;
    chk("midrst_we", sram_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_host_ready", host_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wdata", sram_wdata, 0);
    tick();
    tick();
    rst = 1'b0;
    host_valid = 1'b1;
    host_data = 8'h77;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("postrst_host_ready", host_ready, 0);
      chk("postrst_busy", busy, 0);
    end
    host_valid = 1'b0;
    chk("midrst_no_writes", wa_q.size() - wb, 0);
`ifdef FB_WINDOW_EN
    run_frame(0, 2, 0, 1, 0, 1'b0);
`else
    run_frame(0, SS - 1, 0, GS - 1, 1, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
